instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit instruction words stored.
REQ-002 Parameter LATENCY, default 2, legal 1..4, meaning cycles from request acceptance to response valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_addr  input  64  byte address of instruction (the PC).
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 flush  input  1  cancel any in-flight or held fetch (branch taken).
REQ-009 resp_valid  output  1  response word present.
REQ-010 resp_ready  input  1  consumer takes response this cycle.
REQ-011 resp_instruction  output  32  fetched instruction word.
REQ-012 resp_addr  output  64  byte address the response belongs to.
REQ-013 resp_fault  output  1  request was misaligned or out of range.
REQ-014 prog_we  input  1  preload write enable.
REQ-015 prog_addr  input  64  byte address of preload word.
REQ-016 prog_data  input  32  preload data.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, HOLD; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-018 req_ready SHALL be 1 in IDLE, 1 in HOLD only when resp_ready is 1, 0 in BUSY, and 0 in any cycle where flush is 1.
REQ-019 On acceptance SHALL capture req_addr, read memory word index req_addr[63:2], load latency counter with LATENCY-1, and enter BUSY.
REQ-020 BUSY SHALL decrement the counter each cycle; when counter is 0 the next edge enters HOLD with resp_valid=1, giving resp_valid exactly LATENCY cycles after the acceptance edge.
REQ-021 HOLD SHALL keep resp_valid, resp_instruction, resp_addr, resp_fault stable until resp_ready=1.
REQ-022 HOLD with resp_ready=1 and req_valid=0 SHALL go to IDLE with resp_valid=0 next cycle.
REQ-023 HOLD with resp_ready=1 and req_valid=1 SHALL accept the new request the same edge (back-to-back), go to BUSY, and drop resp_valid.
REQ-024 Fault SHALL be flagged when req_addr[1:0]!=0 or req_addr[63:2]>=DEPTH_WORDS; a fault response has the same latency, resp_fault=1 and resp_instruction=32'hD503201F (NOP); memory is not read.
REQ-025 Non-fault responses SHALL have resp_fault=0 and resp_addr equal to the accepted req_addr.
REQ-026 Memory data SHALL be sampled at the acceptance edge; a prog_we write to the same word on that edge returns the old word (read-before-write).
REQ-027 prog_we=1 SHALL write prog_data to word prog_addr[63:2] on the rising edge in any state; writes with misaligned or out-of-range prog_addr are ignored.
REQ-028 flush=1 SHALL force IDLE on the next edge from any state, clear resp_valid, discard the in-flight fetch, and block acceptance that cycle (flush wins over req_valid and resp_ready).
REQ-029 resp_ready with resp_valid=0 SHALL be ignored.

Reset
REQ-030 rst=0 SHALL asynchronously force state IDLE, counter 0, resp_valid 0, resp_instruction 0, resp_addr 0, resp_fault 0.
REQ-031 req_ready SHALL be 0 while rst=0 and 1 from the first cycle after rst rises (IDLE).
REQ-032 Memory contents SHALL NOT be altered by reset.
REQ-033 Reset asserted mid-BUSY or mid-HOLD SHALL discard the fetch; no response appears after release.

Verification
REQ-034 Preload word 0=32'h8B020020, word 1=32'hD2800141; LATENCY=2; request 0x0 at edge N, resp_ready=1 -> resp_valid at N+2, instruction 32'h8B020020, addr 0x0, fault 0.
REQ-035 Back-to-back: hold resp_ready=0 for 3 cycles in HOLD, then resp_ready=1 with request 0x4 -> outputs stable 3 cycles, then 32'hD2800141 two cycles after acceptance.
REQ-036 Request 0x6 and request 64'h1000 (DEPTH_WORDS=1024) -> each resp_fault=1, instruction 32'hD503201F, after LATENCY.
REQ-037 Request 0x0 accepted, flush=1 on next cycle with req_valid=1 -> no response, req_ready=0 that cycle, IDLE after, next request served normally.
REQ-038 prog_we to word 0 with 32'hFFFFFFFF on the acceptance edge of request 0x0 -> response 32'h8B020020; repeat request -> 32'hFFFFFFFF.
REQ-039 Assert rst=0 mid-BUSY between clock edges -> resp_valid=0 and outputs zero immediately; after release req_ready=1, no stale response.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: it accepts one fetch at a time and returns the
// word LATENCY cycles later. The response is held until the consumer takes it.
module instr_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instruction,
    output logic [63:0] resp_addr,
    output logic        resp_fault,
    input  logic        prog_we,
    input  logic [63:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] NOP_WORD = 32'hD503201F;
    localparam logic [2:0]  CNT_LOAD = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic [2:0]  cnt;
    logic        req_fault;
    logic        prog_ok;
    logic [31:0] fetch_word;
    logic [63:0] fetch_addr;
    logic        fetch_fault;

    logic [31:0] mem [DEPTH_WORDS];

    // Out-of-range addresses never reach the memory index, so truncation is safe.
    assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[63:2] >= 62'(DEPTH_WORDS));
    assign prog_ok   = (prog_addr[1:0] == 2'b00) && (prog_addr[63:2] < 62'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) begin
            mem[prog_addr[AW+1:2]] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        accept     = 1'b0;

        unique case (state)
            IDLE:    req_ready = 1'b1;
            BUSY:    req_ready = 1'b0;
            HOLD:    req_ready = resp_ready;
            default: req_ready = 1'b0;
        endcase

        // Flush beats everything, including a consumer taking the held word.
        if (flush || !rst) begin
            req_ready = 1'b0;
        end

        accept = req_valid && req_ready;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 3'd0) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    next_state = BUSY;
                end else if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        if (flush) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt              <= 3'd0;
            fetch_word       <= 32'd0;
            fetch_addr       <= 64'd0;
            fetch_fault      <= 1'b0;
            resp_valid       <= 1'b0;
            resp_instruction <= 32'd0;
            resp_addr        <= 64'd0;
            resp_fault       <= 1'b0;
        end else if (flush) begin
            cnt        <= 3'd0;
            resp_valid <= 1'b0;
        end else if (accept) begin
            // The memory is read here, so a same-edge preload write is not seen.
            fetch_word  <= req_fault ? NOP_WORD : mem[req_addr[AW+1:2]];
            fetch_addr  <= req_addr;
            fetch_fault <= req_fault;
            cnt         <= CNT_LOAD;
            resp_valid  <= 1'b0;
        end else begin
            unique case (state)
                BUSY: begin
                    if (cnt == 3'd0) begin
                        resp_valid       <= 1'b1;
                        resp_instruction <= fetch_word;
                        resp_addr        <= fetch_addr;
                        resp_fault       <= fetch_fault;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: expected words are queued when a
// request is accepted and compared while the response is presented.
module tb_instr_mem_responder;

    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'hD503201F;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] addr;
        logic        fault;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instruction;
    logic [63:0] resp_addr;
    logic        resp_fault;
    logic        prog_we;
    logic [63:0] prog_addr;
    logic [31:0] prog_data;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    int          num_checks = 0;
    int          num_errors = 0;
    int          cycle = 0;
    bit          prev_valid = 0;

    instr_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .flush           (flush),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_instruction(resp_instruction),
        .resp_addr       (resp_addr),
        .resp_fault      (resp_fault),
        .prog_we         (prog_we),
        .prog_addr       (prog_addr),
        .prog_data       (prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // The head entry is compared every cycle it is presented, so held outputs are checked too.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                if (!prev_valid) begin
                    checkOutput("latency", 64'(cycle), 64'(sb[0].cyc));
                end
                checkOutput("resp_instruction", 64'(resp_instruction), 64'(sb[0].instr));
                checkOutput("resp_addr", resp_addr, sb[0].addr);
                checkOutput("resp_fault", 64'(resp_fault), 64'(sb[0].fault));
                if (resp_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
        prev_valid = rst && resp_valid;
    end

    task automatic progWrite(input logic [63:0] addr, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        if (addr[1:0] == 2'b00 && addr[63:2] < 62'(DEPTH)) begin
            model_mem[addr[11:2]] = data;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] addr, input bit expect_resp,
                                 input bit with_write, input logic [63:0] waddr,
                                 input logic [31:0] wdata);
        bit   got;
        exp_t e;
        req_valid = 1'b1;
        req_addr  = addr;
        if (with_write) begin
            prog_we   = 1'b1;
            prog_addr = waddr;
            prog_data = wdata;
        end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                if (expect_resp) begin
                    e.fault = (addr[1:0] != 2'b00) || (addr[63:2] >= 62'(DEPTH));
                    e.instr = e.fault ? NOP : model_mem[addr[11:2]];
                    e.addr  = addr;
                    e.cyc   = cycle + 1 + LAT;
                    sb.push_back(e);
                end
                if (with_write && waddr[1:0] == 2'b00 && waddr[63:2] < 62'(DEPTH)) begin
                    model_mem[waddr[11:2]] = wdata;
                end
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        prog_we   = 1'b0;
        if (!got) begin
            checkOutput("req_timeout", 64'(req_ready), 64'd1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid();
        for (int i = 0; i < 20 && !resp_valid; i++) begin
            @(negedge clk);
        end
        checkOutput("wait_valid", 64'(resp_valid), 64'd1);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 64'd0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = 64'd0;
        prog_data  = 32'd0;

        #12;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);

        // Preload; the last two writes are misaligned / out of range and must be dropped.
        progWrite(64'h0, 32'h8B020020);
        progWrite(64'h4, 32'hD2800141);
        progWrite(64'h5, 32'hDEADBEEF);
        progWrite(64'h1000, 32'hCAFEF00D);

        $display("[TB] basic fetch");
        applyStimulus(64'h0, 1, 0, 64'h0, 32'h0);
        drain();

        $display("[TB] held response then back-to-back");
        resp_ready = 1'b0;
        applyStimulus(64'h0, 1, 0, 64'h0, 32'h0);
        waitValid();
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        applyStimulus(64'h4, 1, 0, 64'h0, 32'h0);
        drain();

        $display("[TB] faulting fetches");
        applyStimulus(64'h6, 1, 0, 64'h0, 32'h0);
        drain();
        applyStimulus(64'h1000, 1, 0, 64'h0, 32'h0);
        drain();

        $display("[TB] flush while busy");
        applyStimulus(64'h0, 0, 0, 64'h0, 32'h0);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'h4;
        @(negedge clk);
        checkOutput("flush_busy_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("after_flush_req_ready", 64'(req_ready), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(64'h4, 1, 0, 64'h0, 32'h0);
        drain();

        $display("[TB] flush while holding");
        resp_ready = 1'b0;
        applyStimulus(64'h4, 1, 0, 64'h0, 32'h0);
        waitValid();
        @(posedge clk);
        #1;
        flush      = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 64'h0;
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("flush_hold_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_hold_resp_valid", 64'(resp_valid), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] read-before-write");
        applyStimulus(64'h0, 1, 1, 64'h0, 32'hFFFFFFFF);
        drain();
        applyStimulus(64'h0, 1, 0, 64'h0, 32'h0);
        drain();

        $display("[TB] reset mid-busy");
        applyStimulus(64'h4, 0, 0, 64'h0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_resp_instruction", 64'(resp_instruction), 64'd0);
        checkOutput("rst_resp_addr", resp_addr, 64'd0);
        checkOutput("rst_resp_fault", 64'(resp_fault), 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        #3;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_release_req_ready", 64'(req_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(64'h4, 1, 0, 64'h0, 32'h0);
        drain();

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
